obstacle_field: RTL and testbench
=================================

OBSTACLE_FIELD -- requirements
Module: obstacle_field

Interface
REQ-001 SHALL have parameter ROWS, default 30, number of field rows (one bit per row per column).
REQ-002 SHALL have parameter COLS, default 40, number of field columns; column 0 is the insertion column.
REQ-003 SHALL have parameter GAP, default 10, open rows per wall column; range 1..ROWS-2.
REQ-004 SHALL have parameter SPACING, default 8, empty columns between walls; minimum 1.
REQ-005 SHALL have parameter PIPE_W, default 1, consecutive wall columns per obstacle; minimum 1.
REQ-006 SHALL have parameter PASS_COL, default 36, column at which an obstacle counts as passed; range 0..COLS-1.
REQ-007 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-008 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have port step  in  1  one-cycle scroll request (frame tick).
REQ-010 SHALL have port run  in  1  scroll enable; low freezes field, generator and score.
REQ-011 SHALL have port clear  in  1  synchronous clear of field, generator and score.
REQ-012 SHALL have port q_row/q_col  in  clog2(ROWS)/clog2(COLS)  read address.
REQ-013 SHALL have port q_data  out  1  occupancy of addressed cell.
REQ-014 SHALL have port bird_row/bird_col  in  clog2(ROWS)/clog2(COLS)  collision probe address.
REQ-015 SHALL have port hit  out  1  probe cell occupied.
REQ-016 SHALL have ports pass (out, 1, one-cycle pulse per obstacle passed) and score (out, 8, passed count).

Function
REQ-017 Scroll SHALL occur on a rising edge with step=1, run=1, clear=0: every row shifts one column towards COLS-1, column 0 takes the generated column, column COLS-1 is discarded; visible the next cycle.
REQ-018 Generator FSM SHALL have states SPACE and WALL; SPACE inserts all-zero columns, WALL inserts columns with 1s except rows gap_top..gap_top+GAP-1.
REQ-019 From reset, SPACE SHALL emit SPACING empty columns, then WALL SHALL emit PIPE_W wall columns with one latched gap_top, then return to SPACE; period SPACING+PIPE_W scrolls.
REQ-020 gap_top SHALL be latched on entry to WALL and SHALL lie in 1..ROWS-GAP-1, so rows 0 and ROWS-1 are always wall.
REQ-021 A lead-marker shift register (COLS bits) SHALL scroll with the field, set only for the first column of each obstacle.
REQ-022 pass SHALL pulse for exactly one cycle, the cycle after a scroll moves a lead marker into PASS_COL; score SHALL increment on the same edge, wrapping 255->0.
REQ-023 q_data SHALL be registered, one-cycle latency, reflecting field state after that edge's update; out-of-range row/col SHALL return 0.
REQ-024 hit SHALL be registered, one-cycle latency, same rules as q_data on bird_row/bird_col.
REQ-025 clear SHALL take priority over step on the same edge; field, markers, score zero; FSM to SPACE with full SPACING count.
REQ-026 step with run=0 SHALL be ignored, not queued.

Reset
REQ-027 resetn low SHALL asynchronously zero field, markers, score, pass, q_data, hit; FSM SHALL be SPACE with full SPACING count; gap source to seed state.
REQ-028 Reset asserted mid-WALL SHALL discard the partial obstacle; the first column after release is empty.

Configuration
REQ-029 With OBSTACLE_LFSR_EN defined, gap_top SHALL derive from a 16-bit maximal LFSR (seed 16'hACE1) advanced once per WALL entry, mapped into range by modulo.
REQ-030 Without OBSTACLE_LFSR_EN, gap_top SHALL cycle a fixed 4-entry table {5,15,10,12} clipped into range, restarting at entry 0 on reset/clear.

Structure
REQ-031 Package obstacle_pkg SHALL hold the FSM state type, LFSR seed/taps and the 4-entry gap table.
REQ-032 Gap selection (LFSR or table) SHALL be sub-module obstacle_gap_gen with next/gap_top interface.

Verification
REQ-033 Defaults, reset, 8 steps -> field all zero; step 9 -> column 0 = wall, gap rows 5..14 zero (table mode).
REQ-034 49 steps after reset -> first wall at column 40-... discarded; pass pulse exactly once at step 45 (lead reaches col 36), score=1.
REQ-035 Probe bird_row=0,bird_col=0 after step 9 -> hit=1 next cycle; bird_row=7 -> hit=0.
REQ-036 step and clear same edge with populated field -> field zero, score 0, next 8 steps empty.
REQ-037 step pulses with run=0 -> field, score, q_data unchanged; q_row=31 -> q_data=0.
REQ-038 OBSTACLE_LFSR_EN, 1000 obstacles -> every gap_top within 1..19, rows 0 and 29 always set.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types and constants for the scrolling obstacle field: generator state,
// gap-source LFSR constants and the fixed gap-position table.
package obstacle_pkg;

  typedef enum logic {
    GEN_SPACE,
    GEN_WALL
  } gen_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int GAP_TABLE [4] = '{5, 15, 10, 12};

  function automatic int gap_clip(input int v, input int hi);
    if (v < 1) return 1;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/obstacle_gap_gen.sv
// Gap position source: LFSR modulo range with OBSTACLE_LFSR_EN, else a 4-entry table.
// gap_top is combinational from current state; next advances it by one entry.
module obstacle_gap_gen
  import obstacle_pkg::*;
#(
  parameter int ROWS = 30,
  parameter int GAP  = 10,
  parameter int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          next,
  output logic [RW-1:0] gap_top
);

  localparam int GAP_MAX = ROWS - GAP - 1;

`ifdef OBSTACLE_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= LFSR_SEED;
    end else if (clear) begin
      lfsr_q <= LFSR_SEED;
    end else if (next) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign gap_top = RW'(1 + (int'(lfsr_q) % GAP_MAX));
`else
  logic [1:0] idx_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q <= 2'd0;
    end else if (clear) begin
      idx_q <= 2'd0;
    end else if (next) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  assign gap_top = RW'(gap_clip(GAP_TABLE[idx_q], GAP_MAX));
`endif

endmodule

// File: rtl/obstacle_field.sv
// Scrolling ROWS x COLS obstacle bitmap with wall generator, pass scoring and two read ports.
// Reads/probe one-cycle registered; no backpressure. Gap source selected by OBSTACLE_LFSR_EN.
module obstacle_field
  import obstacle_pkg::*;
#(
  parameter int ROWS     = 30,
  parameter int COLS     = 40,
  parameter int GAP      = 10,
  parameter int SPACING  = 8,
  parameter int PIPE_W   = 1,
  parameter int PASS_COL = 36
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    step,
  input  logic                    run,
  input  logic                    clear,
  input  logic [$clog2(ROWS)-1:0] q_row,
  input  logic [$clog2(COLS)-1:0] q_col,
  output logic                    q_data,
  input  logic [$clog2(ROWS)-1:0] bird_row,
  input  logic [$clog2(COLS)-1:0] bird_col,
  output logic                    hit,
  output logic                    pass,
  output logic [7:0]              score
);

  localparam int RW      = $clog2(ROWS);
  localparam int CNT_MAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [ROWS-1:0] field_q [COLS];
  logic [ROWS-1:0] field_d [COLS];
  logic [COLS-1:0] lead_q, lead_d;
  gen_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [RW-1:0]   gap_q;
  logic [RW-1:0]   gap_top;
  logic [ROWS-1:0] gen_col;
  logic            gen_lead;
  logic            gap_next;
  logic            scroll;
  logic            pass_q;
  logic [7:0]      score_q;
  logic            q_data_q, q_data_d;
  logic            hit_q, hit_d;

  assign scroll   = step & run & ~clear;
  assign gen_lead = (state_q == GEN_WALL) && (cnt_q == CW'(PIPE_W));
  assign gap_next = scroll && (state_q == GEN_SPACE) && (cnt_q == CW'(1));

  obstacle_gap_gen #(
    .ROWS (ROWS),
    .GAP  (GAP),
    .RW   (RW)
  ) u_gap_gen (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (clear),
    .next    (gap_next),
    .gap_top (gap_top)
  );

  always_comb begin
    gen_col = '0;
    if (state_q == GEN_WALL) begin
      for (int r = 0; r < ROWS; r++) begin
        gen_col[r] = !((r >= int'(gap_q)) && (r < int'(gap_q) + GAP));
      end
    end
  end

  always_comb begin
    field_d = field_q;
    lead_d  = lead_q;
    if (clear) begin
      for (int c = 0; c < COLS; c++) field_d[c] = '0;
      lead_d = '0;
    end else if (scroll) begin
      field_d[0] = gen_col;
      for (int c = 1; c < COLS; c++) field_d[c] = field_q[c-1];
      lead_d = {lead_q[COLS-2:0], gen_lead};
    end
  end

  // Reads look at the post-update field so the result matches state after this edge
  always_comb begin
    q_data_d = 1'b0;
    hit_d    = 1'b0;
    if ((int'(q_row) < ROWS) && (int'(q_col) < COLS)) q_data_d = field_d[q_col][q_row];
    if ((int'(bird_row) < ROWS) && (int'(bird_col) < COLS)) hit_d = field_d[bird_col][bird_row];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= GEN_SPACE;
      cnt_q   <= CW'(SPACING);
      gap_q   <= '0;
    end else if (clear) begin
      state_q <= GEN_SPACE;
      cnt_q   <= CW'(SPACING);
    end else if (scroll) begin
      case (state_q)
        GEN_SPACE: begin
          if (cnt_q == CW'(1)) begin
            state_q <= GEN_WALL;
            cnt_q   <= CW'(PIPE_W);
            gap_q   <= gap_top;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          if (cnt_q == CW'(1)) begin
            state_q <= GEN_SPACE;
            cnt_q   <= CW'(SPACING);
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int c = 0; c < COLS; c++) field_q[c] <= '0;
      lead_q   <= '0;
      pass_q   <= 1'b0;
      score_q  <= 8'd0;
      q_data_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      field_q  <= field_d;
      lead_q   <= lead_d;
      pass_q   <= scroll && lead_d[PASS_COL];
      q_data_q <= q_data_d;
      hit_q    <= hit_d;
      if (clear) begin
        score_q <= 8'd0;
      end else if (scroll && lead_d[PASS_COL]) begin
        score_q <= score_q + 8'd1;
      end
    end
  end

  assign q_data = q_data_q;
  assign hit    = hit_q;
  assign pass   = pass_q;
  assign score  = score_q;

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field at default parameters (table gap mode).
module tb_obstacle_field;

  logic       clk = 1'b0;
  logic       resetn, step, run, clear;
  logic [4:0] q_row, bird_row;
  logic [5:0] q_col, bird_col;
  logic       q_data, hit, pass;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;

  obstacle_field dut (
    .clk      (clk),
    .resetn   (resetn),
    .step     (step),
    .run      (run),
    .clear    (clear),
    .q_row    (q_row),
    .q_col    (q_col),
    .q_data   (q_data),
    .bird_row (bird_row),
    .bird_col (bird_col),
    .hit      (hit),
    .pass     (pass),
    .score    (score)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_step;
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic read_col(input int c, output logic [29:0] v);
    v = '0;
    for (int r = 0; r < 30; r++) begin
      q_row = 5'(r);
      q_col = 6'(c);
      tick();
      v[r] = q_data;
    end
  endtask

  task automatic count_ones(output int n);
    logic [29:0] v;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      read_col(c, v);
      n += $countones(v);
    end
  endtask

  initial begin
    logic [29:0] v;
    int n, pass_cnt, pass_at, wall_bad, space_bad;

    resetn = 1'b0; step = 1'b0; run = 1'b1; clear = 1'b0;
    q_row = '0; q_col = '0; bird_row = '0; bird_col = '0;
    #12;
    check("rst_q_data", q_data, 0);
    check("rst_hit", hit, 0);
    check("rst_pass", pass, 0);
    check("rst_score", score, 0);
    resetn = 1'b1;
    tick();

    // first obstacle: 8 empty columns then a wall with gap rows 5..14
    repeat (8) do_step();
    count_ones(n);
    check("empty_after_8", n, 0);
    do_step();
    read_col(0, v);
    check("wall1_col0", v, 32'h3FFF801F);
    read_col(1, v);
    check("wall1_col1", v, 0);

    bird_col = 6'd0;
    bird_row = 5'd0;  tick(); check("hit_r0", hit, 1);
    bird_row = 5'd7;  tick(); check("hit_r7", hit, 0);
    bird_row = 5'd14; tick(); check("hit_r14", hit, 0);
    bird_row = 5'd15; tick(); check("hit_r15", hit, 1);
    bird_row = 5'd29; tick(); check("hit_r29", hit, 1);
    bird_row = 5'd0; bird_col = 6'd40; tick(); check("hit_col_oor", hit, 0);

    pass_cnt = 0;
    pass_at  = 0;
    for (int s = 10; s <= 49; s++) begin
      if (s == 45) check("score_before_pass", score, 0);
      do_step();
      if (pass) begin
        pass_cnt++;
        pass_at = s;
      end
      if (s == 45) begin
        tick();
        check("pass_one_cycle", pass, 0);
      end
    end
    check("pass_count", pass_cnt, 1);
    check("pass_step", pass_at, 45);
    check("score_after_49", score, 1);
    read_col(39, v); check("col39_discarded", v, 0);
    read_col(31, v); check("col31_gap15", v, 32'h3E007FFF);
    read_col(22, v); check("col22_gap10", v, 32'h3FF003FF);
    read_col(13, v); check("col13_gap12", v, 32'h3FC00FFF);
    read_col(4, v);  check("col4_gap5", v, 32'h3FFF801F);
    read_col(32, v); check("col32_empty", v, 0);

    // run low: steps ignored and not queued
    q_row = 5'd0; q_col = 6'd31; tick();
    check("frz_q_before", q_data, 1);
    run = 1'b0;
    repeat (5) do_step();
    check("frz_q_after", q_data, 1);
    check("frz_score", score, 1);
    read_col(31, v); check("frz_col31", v, 32'h3E007FFF);
    run = 1'b1;
    do_step();
    read_col(32, v); check("resume_col32", v, 32'h3E007FFF);
    read_col(33, v); check("resume_col33", v, 0);
    q_row = 5'd31; q_col = 6'd32; tick(); check("q_row_oor", q_data, 0);
    q_row = 5'd0;  q_col = 6'd45; tick(); check("q_col_oor", q_data, 0);

    // clear wins over step on the same edge
    clear = 1'b1; step = 1'b1;
    tick();
    clear = 1'b0; step = 1'b0;
    check("clr_score", score, 0);
    check("clr_pass", pass, 0);
    count_ones(n);
    check("clr_field", n, 0);
    repeat (8) do_step();
    count_ones(n);
    check("clr_8_empty", n, 0);
    do_step();
    read_col(0, v);
    check("clr_table_restart", v, 32'h3FFF801F);

    // reset while the generator sits in WALL
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (8) do_step();
    resetn = 1'b0;
    #3;
    check("midwall_rst_q", q_data, 0);
    resetn = 1'b1;
    tick();
    do_step();
    read_col(0, v);
    check("midwall_first_empty", v, 0);
    repeat (7) do_step();
    count_ones(n);
    check("midwall_8_empty", n, 0);
    do_step();
    read_col(0, v);
    check("midwall_wall", v, 32'h3FFF801F);

    // long run: edge rows always wall, spacing columns empty, score wraps
    resetn = 1'b0; tick(); resetn = 1'b1; tick();
    q_row = 5'd0; q_col = 6'd0; bird_row = 5'd29; bird_col = 6'd0;
    wall_bad  = 0;
    space_bad = 0;
    for (int k = 0; k < 1000; k++) begin
      repeat (8) do_step();
      if (q_data !== 1'b0 || hit !== 1'b0) space_bad++;
      do_step();
      if (q_data !== 1'b1 || hit !== 1'b1) wall_bad++;
    end
    check("long_space_cols", space_bad, 0);
    check("long_edge_rows", wall_bad, 0);
    check("long_score_wrap", score, 228);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
